// File: rtl/ibwt_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ibwt_decoder_pkg
// Shared definitions for the inverse Burrows-Wheeler transform decoder:
// default symbol width, default block length and the controller state type.
// ---------------------------------------------------------------------------
package ibwt_decoder_pkg;

  localparam int IBWT_ELEMENT_LEN = 8;  // symbol width in bits
  localparam int IBWT_STRING_LEN  = 8;  // block length in symbols

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUILD  = 2'd1,
    DECODE = 2'd2,
    STREAM = 2'd3
  } state_e;

endpackage

// File: rtl/ibwt_lf_rank.sv
// ---------------------------------------------------------------------------
// ibwt_lf_rank
// Combinational LF-mapping rank for one entry k of the BWT last column:
//   lf = #{j : L[j] < L[k]} + #{j < k : L[j] == L[k]}
// Ties are broken by position, so equal symbols keep their original order.
// Ports:
//   l_buf_i  last column L[0..STRING_LEN-1]
//   k_i      entry being ranked
//   lf_o     LF[k]; always fits, since the sum is at most STRING_LEN-1
// ---------------------------------------------------------------------------
module ibwt_lf_rank #(
  parameter int STRING_LEN  = 8,
  parameter int ELEMENT_LEN = 8
) (
  input  logic [ELEMENT_LEN-1:0]        l_buf_i [0:STRING_LEN-1],
  input  logic [$clog2(STRING_LEN)-1:0] k_i,
  output logic [$clog2(STRING_LEN)-1:0] lf_o
);

  localparam int IW = $clog2(STRING_LEN);

  logic [ELEMENT_LEN-1:0] sym_k;
  logic [IW-1:0]          acc;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    sym_k = l_buf_i[k_i];
    acc   = '0;
    for (int j = 0; j < STRING_LEN; j++) begin
      if ((l_buf_i[j] < sym_k) || ((l_buf_i[j] == sym_k) && (j < int'(k_i))))
        acc = acc + IW'(1);
    end
    lf_o = acc;
  end

endmodule

// File: rtl/ibwt_decoder.sv
// ---------------------------------------------------------------------------
// ibwt_decoder
// Inverse Burrows-Wheeler transform of one block. A block is captured on
// start, then:
//   BUILD  : STRING_LEN cycles, one LF table entry per cycle
//   DECODE : STRING_LEN cycles, walking p <- LF[p] and filling S from the end
//   STREAM : S[0..STRING_LEN-1] is offered with a valid/ready handshake
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   start      one-cycle request, honoured only while idle
//   data_in    BWT last column L[0..STRING_LEN-1]
//   prim_idx   sorted-row index of the original string
//   busy       high while a block is in flight
//   out_data   reconstructed symbol (zero when out_valid is low)
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data this cycle
//   done       one-cycle pulse after the final symbol is accepted
// ---------------------------------------------------------------------------
module ibwt_decoder
  import ibwt_decoder_pkg::*;
#(
  parameter int STRING_LEN  = IBWT_STRING_LEN,
  parameter int ELEMENT_LEN = IBWT_ELEMENT_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ELEMENT_LEN-1:0]        data_in [0:STRING_LEN-1],
  input  logic [$clog2(STRING_LEN)-1:0] prim_idx,
  output logic                          busy,
  output logic [ELEMENT_LEN-1:0]        out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);

  localparam int            IW   = $clog2(STRING_LEN);
  localparam logic [IW-1:0] LAST = IW'(STRING_LEN - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;   // k in BUILD, n in DECODE, c in STREAM
  logic [IW-1:0] p_q, p_d;
  logic          done_q, done_d;

  logic [ELEMENT_LEN-1:0] l_buf_q [0:STRING_LEN-1];
  logic [IW-1:0]          lf_q    [0:STRING_LEN-1];
  logic [ELEMENT_LEN-1:0] s_buf_q [0:STRING_LEN-1];

  logic [IW-1:0] lf_k;
  logic          cnt_last;
  logic          xfer;

  ibwt_lf_rank #(
    .STRING_LEN (STRING_LEN),
    .ELEMENT_LEN(ELEMENT_LEN)
  ) u_lf_rank (
    .l_buf_i(l_buf_q),
    .k_i    (cnt_q),
    .lf_o   (lf_k)
  );

  assign cnt_last  = (cnt_q == LAST);
  assign out_valid = (state_q == STREAM);
  assign xfer      = out_valid && out_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  // Gated so that the unreset symbol buffer never reaches the port.
  assign out_data  = out_valid ? s_buf_q[cnt_q] : '0;

  // The counter wraps to zero on its last value (STRING_LEN is a power of
  // two), so each phase starts the next one with a cleared index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUILD;
          cnt_d   = '0;
          p_d     = prim_idx;
        end
      end
      BUILD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) state_d = DECODE;
      end
      DECODE: begin
        cnt_d = cnt_q + 1'b1;
        p_d   = lf_q[p_q];
        if (cnt_last) state_d = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the buffers have no reset; each is fully rewritten before it is
  // read, and leaving them unreset lets them map onto plain storage.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) l_buf_q <= data_in;
    if (state_q == BUILD)         lf_q[cnt_q] <= lf_k;
    if (state_q == DECODE)        s_buf_q[LAST - cnt_q] <= l_buf_q[p_q];
  end

endmodule
